// File: rtl/register_scoreboard_pkg.sv
// Shared types and sizing for the register scoreboard: usage record layout,
// index width and EFLAGS writer counter width.
package common_params;

  localparam int NREG   = 32;
  localparam int IDX_W  = 5;
  localparam int EF_MAX = 7;
  localparam int EF_W   = 3;

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [EF_W-1:0]  ef_cnt_t;

  // Register usage record produced by the decoder for one instruction.
  typedef struct packed {
    reg_idx_t d;
    reg_idx_t s;
    reg_idx_t t;
    logic     from_gd;
    logic     from_fd;
    logic     to_gd;
    logic     to_fd;
    logic     from_gs;
    logic     from_fs;
    logic     from_gt;
    logic     from_ft;
    logic     from_ef;
    logic     to_ef;
  } rut_t;

endpackage

// File: rtl/register_scoreboard_if.sv
// Issue / writeback / flush bundle between the decode stage and the scoreboard.
// Handshake: an instruction fires on a cycle where issue_valid & issue_ready;
// issue_ready is combinational and never depends on issue_valid.
interface register_scoreboard_if;
  import common_params::*;

  logic             issue_valid;
  rut_t             issue_rut;
  logic             issue_ready;
  logic             wb_g_valid;
  logic [IDX_W-1:0] wb_g_idx;
  logic             wb_f_valid;
  logic [IDX_W-1:0] wb_f_idx;
  logic             wb_ef_valid;
  logic             flush;

  modport master (
    output issue_valid, issue_rut, wb_g_valid, wb_g_idx,
           wb_f_valid, wb_f_idx, wb_ef_valid, flush,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rut, wb_g_valid, wb_g_idx,
           wb_f_valid, wb_f_idx, wb_ef_valid, flush,
    output issue_ready
  );

endinterface

// File: rtl/register_scoreboard_file.sv
// One register file's pending-write bits with a set port, a clear port and
// three lookup ports that see same-cycle clears (writeback bypass).
module scoreboard_file #(
  parameter int NREG  = 32,
  parameter int IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  set_en,
  input  logic [IDX_W-1:0]      set_idx,
  input  logic                  clr_en,
  input  logic [IDX_W-1:0]      clr_idx,
  input  logic [2:0][IDX_W-1:0] look_idx,
  output logic [2:0]            look_pend
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Clear first so a same-cycle set on the same index wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_idx] = 1'b0;
    if (set_en) pend_d[set_idx] = 1'b1;
    if (flush)  pend_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_comb begin
    look_pend = '0;
    for (int i = 0; i < 3; i++) begin
      look_pend[i] = pend_q[look_idx[i]] & ~(clr_en && (clr_idx == look_idx[i]));
    end
  end

endmodule

// File: rtl/register_scoreboard.sv
// In-order issue scoreboard: GPR/FPR pending-write tracking, EFLAGS writer
// counting, RAW/WAW/EFLAGS hazard detection and a stall-cycle counter.
module register_scoreboard #(
  parameter int NREG   = 32,
  parameter int IDX_W  = 5,
  parameter int EF_MAX = 7
) (
  input  logic                        clk,
  input  logic                        rstn,
  register_scoreboard_if.slave        bus,
  output logic [common_params::EF_W-1:0] ef_pending,
  output logic [31:0]                 stall_cycles
);
  import common_params::rut_t;
  import common_params::EF_W;

  localparam logic [EF_W-1:0] EF_LIM = EF_W'(EF_MAX);

  rut_t                  rut;
  logic [2:0][IDX_W-1:0] look_idx;
  logic [2:0]            gpr_pend;
  logic [2:0]            fpr_pend;
  logic [EF_W-1:0]       ef_cnt;
  logic [EF_W-1:0]       ef_eff;
  logic                  ef_dec;
  logic                  ef_inc;
  logic                  raw_haz;
  logic                  waw_haz;
  logic                  ef_haz;
  logic                  ready;
  logic                  fire;

  assign rut      = bus.issue_rut;
  assign look_idx = {rut.t, rut.s, rut.d};

  scoreboard_file #(.NREG(NREG), .IDX_W(IDX_W)) u_gpr (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (bus.flush),
    .set_en    (fire & rut.to_gd),
    .set_idx   (rut.d),
    .clr_en    (bus.wb_g_valid),
    .clr_idx   (bus.wb_g_idx),
    .look_idx  (look_idx),
    .look_pend (gpr_pend)
  );

  scoreboard_file #(.NREG(NREG), .IDX_W(IDX_W)) u_fpr (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (bus.flush),
    .set_en    (fire & rut.to_fd),
    .set_idx   (rut.d),
    .clr_en    (bus.wb_f_valid),
    .clr_idx   (bus.wb_f_idx),
    .look_idx  (look_idx),
    .look_pend (fpr_pend)
  );

  // A retire with nothing outstanding is dropped so the counter never wraps.
  assign ef_dec = bus.wb_ef_valid && (ef_cnt != '0);
  assign ef_eff = ef_cnt - EF_W'(ef_dec);

  assign raw_haz = (rut.from_gd & gpr_pend[0]) | (rut.from_gs & gpr_pend[1]) |
                   (rut.from_gt & gpr_pend[2]) | (rut.from_fd & fpr_pend[0]) |
                   (rut.from_fs & fpr_pend[1]) | (rut.from_ft & fpr_pend[2]);
  assign waw_haz = (rut.to_gd & gpr_pend[0]) | (rut.to_fd & fpr_pend[0]);
  assign ef_haz  = (rut.from_ef && (ef_eff != '0)) || (rut.to_ef && (ef_eff == EF_LIM));

  assign ready           = ~(raw_haz | waw_haz | ef_haz) & ~bus.flush;
  assign bus.issue_ready = ready;
  assign fire            = bus.issue_valid & ready;
  assign ef_inc          = fire & rut.to_ef;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          ef_cnt <= '0;
    else if (bus.flush) ef_cnt <= '0;
    else                ef_cnt <= ef_cnt + EF_W'(ef_inc) - EF_W'(ef_dec);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cycles <= '0;
    else if (bus.issue_valid & ~ready & ~bus.flush)
      stall_cycles <= stall_cycles + 32'd1;
  end

  assign ef_pending = ef_cnt;

endmodule

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32: registers per file (GPR and FPR).
REQ-002 SHALL have parameter IDX_W, default 5: register index width, $clog2(NREG).
REQ-003 SHALL have parameter EF_MAX, default 7: maximum outstanding EFLAGS writers.
REQ-004 Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- issue_valid  in  1  decoded instruction presented.
- issue_rut  in  rut_t  register usage record: d/s/t indices, from_gd/fd, to_gd/fd, from_gs/fs/gt/ft, from_ef, to_ef.
- issue_ready  out  1  no hazard; the instruction may issue.
- wb_g_valid  in  1  GPR writeback this cycle.
- wb_g_idx  in  IDX_W  GPR index written.
- wb_f_valid  in  1  FPR writeback this cycle.
- wb_f_idx  in  IDX_W  FPR index written.
- wb_ef_valid  in  1  one EFLAGS write retired.
- flush  in  1  pipeline squash.
- ef_pending  out  3  outstanding EFLAGS writer count.
- stall_cycles  out  32  count of cycles with issue_valid & ~issue_ready.

Function
REQ-005 SHALL hold pend_g[NREG] and pend_f[NREG] bits plus the ef_cnt counter (0..EF_MAX).
REQ-006 Effective pending = registered pending & ~(same-cycle writeback to that index); writeback bypasses in the same cycle.
REQ-007 Effective ef_cnt = ef_cnt - wb_ef_valid.
REQ-008 RAW hazard: a set from_gd/from_gs/from_gt flag whose index (d/s/t) is effective-pending in the GPR file; same rule for the f flags against the FPR file.
REQ-009 WAW hazard: to_gd with pend_g[d] effective, or to_fd with pend_f[d] effective.
REQ-010 EFLAGS hazard: from_ef with effective ef_cnt != 0, or to_ef with effective ef_cnt == EF_MAX.
REQ-011 issue_ready SHALL equal ~(any hazard) & ~flush; it is combinational and independent of issue_valid.
REQ-012 Fire = issue_valid & issue_ready; on fire, to_gd sets pend_g[d] and to_fd sets pend_f[d] at the next edge.
REQ-013 When set and clear hit the same index in one cycle, set SHALL win.
REQ-014 ef_cnt next = ef_cnt + (fire & to_ef) - wb_ef_valid; simultaneous increment and decrement SHALL leave it unchanged.
REQ-015 wb_ef_valid with ef_cnt == 0 SHALL be ignored (no underflow).
REQ-016 Writeback to an index that is not pending SHALL be a no-op.
REQ-017 flush SHALL clear all pend bits and ef_cnt at the next edge, ignoring all same-cycle writebacks and issues.
REQ-018 stall_cycles SHALL increment when issue_valid & ~issue_ready & ~flush, and wrap at 2^32-1 -> 0.
REQ-019 The NOP usage record (all flags 0) SHALL never stall.
REQ-020 Latency: a fired write is visible as a hazard from the next cycle; a writeback releases the hazard in the same cycle.

Reset
REQ-021 On rstn low, the block SHALL asynchronously clear all pend bits, ef_cnt and stall_cycles.
REQ-022 Reset assertion mid-operation SHALL discard all outstanding state; issue_ready SHALL be 1 during reset.
REQ-023 Reset deassertion is synchronised externally; the first edge after deassertion is a normal cycle.

Structure
REQ-024 rut_t, IDX_W and the EF counter width SHALL live in the shared common_params package.
REQ-025 One sub-module, scoreboard_file (NREG pending bits, set port, clear port, 3 lookup ports), SHALL be instantiated twice (GPR, FPR).
REQ-026 EFLAGS counter and stall counter logic SHALL stay in the top module.

Verification
REQ-027 ADD d=3 fires; next cycle SUB s=3 -> issue_ready=0 and stall_cycles increments each cycle; wb_g_valid idx=3 -> issue_ready=1 the same cycle.
REQ-028 Eight consecutive ADDs with no EF writeback -> ef_cnt reaches 7 and the 8th stalls; one wb_ef_valid -> the 8th issues and ef_cnt stays 7.
REQ-029 JE with ef_cnt=1 -> stall; wb_ef_valid in the same cycle -> JE issues with ef_cnt ending at 0.
REQ-030 Fire MOVI d=5 while wb_g_valid idx=5 in the same cycle -> pend_g[5]=1 afterwards (set wins).
REQ-031 pend_g[2]=1, ef_cnt=4, flush=1 with issue_valid -> issue_ready=0, no stall count, all state 0 next cycle.
REQ-032 Assert rstn low mid-stall with pend_g[7]=1 -> state clears immediately, issue_ready=1, stall_cycles=0.
